// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request from execute, checks alignment and range,
// issues a single data-memory strobe, extends load data and holds the response until taken.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic [1:0]  mem_store_type,
  output logic [2:0]  mem_read_type,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // a response transfers on a rising edge where resp_valid && resp_ready.
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        req_legal;
  logic        req_misaligned;
  logic        req_out_of_range;
  logic        req_fault;
  logic [32:0] req_end;
  logic [2:0]  req_size;
  logic [31:0] load_ext;

  always_comb begin
    req_size = 3'd0;
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      2'b10:   req_size = 3'd4;
      default: req_size = 3'd0;
    endcase
    // Stores have no unsigned variants, so 1xx is illegal for them.
    if (req_we) req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else        req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                            (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    req_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_end          = {1'b0, req_addr} + {30'd0, req_size};
    req_out_of_range = req_end > 33'(MEM_BYTES);
    req_fault        = !req_legal || req_misaligned || req_out_of_range;
  end

  // Memory returns right-aligned data; bits above the access width are don't-care.
  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{24{mem_dout[7]}}, mem_dout[7:0]};
      3'b001:  load_ext = {{16{mem_dout[15]}}, mem_dout[15:0]};
      3'b010:  load_ext = mem_dout;
      3'b100:  load_ext = {24'd0, mem_dout[7:0]};
      3'b101:  load_ext = {16'd0, mem_dout[15:0]};
      default: load_ext = 32'd0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    funct3_d       = funct3_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    fault_d        = fault_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_re         = 1'b0;
    mem_we         = 1'b0;
    mem_store_type = 2'b00;
    mem_read_type  = 3'b000;
    mem_addr       = 16'd0;
    mem_din        = 32'd0;
    case (state_q)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = 32'd0;
          fault_d  = req_fault;
          state_d  = req_fault ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        // Gated by rst_n so a reset landing on this cycle never commits a write.
        if (rst_n) begin
          mem_addr = addr_q[15:0];
          if (we_q) begin
            mem_we         = 1'b1;
            mem_din        = wdata_q;
            mem_store_type = funct3_q[1:0] + 2'd1;
          end else begin
            mem_re        = 1'b1;
            mem_read_type = {1'b0, funct3_q[1:0] + 2'd1};
          end
        end
        state_d = we_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        rdata_d = load_ext;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-array memory model, hand-computed expected
// load results, latency/strobe counting, backpressure and mid-store reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [1:0]  mem_store_type;
  logic [2:0]  mem_read_type;
  logic [15:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int re_cnt = 0;
  int we_cnt = 0;
  logic [7:0] mem [0:2047];

  load_store_unit #(.MEM_BYTES(2048)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_store_type(mem_store_type),
    .mem_read_type(mem_read_type), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Data memory model: little-endian bytes, registered read with junk above the access width.
  always @(posedge clk) begin
    int a;
    a = int'(mem_addr[10:0]);
    if (mem_we) begin
      we_cnt++;
      mem[a] = mem_din[7:0];
      if (mem_store_type != 2'b01) mem[(a + 1) % 2048] = mem_din[15:8];
      if (mem_store_type == 2'b11) begin
        mem[(a + 2) % 2048] = mem_din[23:16];
        mem[(a + 3) % 2048] = mem_din[31:24];
      end
    end
    if (mem_re) begin
      re_cnt++;
      case (mem_read_type)
        3'b001:  mem_dout <= {24'hDEADBE, mem[a]};
        3'b010:  mem_dout <= {16'hDEAD, mem[(a + 1) % 2048], mem[a]};
        default: mem_dout <= {mem[(a + 3) % 2048], mem[(a + 2) % 2048], mem[(a + 1) % 2048], mem[a]};
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one request, optionally holds resp_ready low, then takes the response.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         input logic [31:0] exp_rdata, input logic exp_fault, input int exp_lat);
    int re0, we0, lat;
    @(negedge clk);
    check_eq({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    re0 = re_cnt; we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      check_eq({tag, " hold valid"}, {31'd0, resp_valid}, 32'd1);
      check_eq({tag, " hold rdata"}, resp_rdata, exp_rdata);
      check_eq({tag, " hold req_ready"}, {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    check_eq({tag, " rdata"}, resp_rdata, exp_rdata);
    check_eq({tag, " fault"}, {31'd0, resp_fault}, {31'd0, exp_fault});
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    check_eq({tag, " valid after take"}, {31'd0, resp_valid}, 32'd0);
    check_eq({tag, " re count"}, 32'(re_cnt - re0), {31'd0, !exp_fault && !we});
    check_eq({tag, " we count"}, 32'(we_cnt - we0), {31'd0, !exp_fault && we});
  endtask

  initial begin
    int we0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst req_ready", {31'd0, req_ready}, 32'd0);
    check_eq("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check_eq("rst resp_rdata", resp_rdata, 32'd0);
    check_eq("rst resp_fault", {31'd0, resp_fault}, 32'd0);
    check_eq("rst mem strobes", {30'd0, mem_re, mem_we}, 32'd0);
    check_eq("rst mem addr/types", {11'd0, mem_addr, mem_store_type, mem_read_type}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    // Junk request with req_valid low must not start anything.
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h1234_5678;
    we0 = we_cnt;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("idle no strobe", 32'(we_cnt - we0), 32'd0);

    run_req("sw 0x10", 1'b1, 3'b010, 32'h10, 32'h8000_00FF, 0, 32'd0, 1'b0, 2);
    run_req("lw 0x10", 1'b0, 3'b010, 32'h10, 32'd0, 0, 32'h8000_00FF, 1'b0, 3);
    run_req("sb 0x20", 1'b1, 3'b000, 32'h20, 32'hFFFF_FF80, 0, 32'd0, 1'b0, 2);
    run_req("lb 0x20", 1'b0, 3'b000, 32'h20, 32'd0, 0, 32'hFFFF_FF80, 1'b0, 3);
    run_req("lbu 0x20", 1'b0, 3'b100, 32'h20, 32'd0, 0, 32'h0000_0080, 1'b0, 3);
    run_req("sh 0x20", 1'b1, 3'b001, 32'h20, 32'h0000_8001, 0, 32'd0, 1'b0, 2);
    run_req("lh 0x20", 1'b0, 3'b001, 32'h20, 32'd0, 0, 32'hFFFF_8001, 1'b0, 3);
    run_req("lhu 0x20", 1'b0, 3'b101, 32'h20, 32'd0, 0, 32'h0000_8001, 1'b0, 3);
    run_req("lw 0x13", 1'b0, 3'b010, 32'h13, 32'd0, 0, 32'd0, 1'b1, 1);
    run_req("sh 0x05", 1'b1, 3'b001, 32'h05, 32'h1234, 0, 32'd0, 1'b1, 1);
    run_req("lw 0x7FE", 1'b0, 3'b010, 32'h7FE, 32'd0, 0, 32'd0, 1'b1, 1);
    run_req("sb 0x800", 1'b1, 3'b000, 32'h800, 32'h55, 0, 32'd0, 1'b1, 1);
    run_req("store f3 100", 1'b1, 3'b100, 32'h40, 32'h55, 0, 32'd0, 1'b1, 1);
    run_req("load f3 011", 1'b0, 3'b011, 32'h40, 32'd0, 0, 32'd0, 1'b1, 1);
    run_req("sh 0x7FE", 1'b1, 3'b001, 32'h7FE, 32'h0000_C3A5, 0, 32'd0, 1'b0, 2);
    run_req("sb 0x7FF", 1'b1, 3'b000, 32'h7FF, 32'h0000_007E, 0, 32'd0, 1'b0, 2);
    run_req("lhu 0x7FE", 1'b0, 3'b101, 32'h7FE, 32'd0, 0, 32'h0000_7EA5, 1'b0, 3);
    run_req("lw bp 0x10", 1'b0, 3'b010, 32'h10, 32'd0, 5, 32'h8000_00FF, 1'b0, 3);
    run_req("sb 0x30", 1'b1, 3'b000, 32'h30, 32'h11, 0, 32'd0, 1'b0, 2);

    // Reset lands during the ISSUE cycle of a byte store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h30; req_wdata = 32'hAA;
    we0 = we_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_eq("midrst mem_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    check_eq("midrst outputs", {resp_valid, resp_fault, mem_re, mem_we, req_ready,
                                mem_store_type, mem_read_type, 22'd0}, 32'd0);
    check_eq("midrst mem_addr", {16'd0, mem_addr}, 32'd0);
    check_eq("midrst mem_din", mem_din, 32'd0);
    check_eq("midrst resp_rdata", resp_rdata, 32'd0);
    check_eq("midrst byte", {24'd0, mem[48]}, 32'h11);
    check_eq("midrst we count", 32'(we_cnt - we0), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_req("lbu 0x30", 1'b0, 3'b100, 32'h30, 32'd0, 0, 32'h0000_0011, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
